// File: rtl/cnn_pkg.sv
// Shared CNN datapath types: byte lanes, OFM reader FSM states and the ReLU clamp.
// Pure declarations, so there is no latency and no flow control.
package cnn_pkg;

   typedef logic [7:0] byte_t;

   localparam int LANES = 4;

   typedef enum logic [2:0] {IDLE, RD, LAT, SEND, FIN} ofm_rd_state_t;

   // Negative bytes clamp to zero; non-negative bytes pass through.
   function automatic byte_t relu(input byte_t b);
      return b[7] ? '0 : b;
   endfunction

endpackage

// File: rtl/ofm_serializer.sv
// Holds one 4-byte OFM word and presents it lane 0 first; OFM_READER_RELU_EN clamps negative bytes.
// Load and advance take one cycle each; the byte index moves only on advance, so stalls hold the output.
module ofm_serializer
   import cnn_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       advance,
   input  byte_t      lane_data [0:LANES-1],
   output logic [1:0] byte_idx,
   output byte_t      out_data
);

   byte_t hold [0:LANES-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < LANES; i++) hold[i] <= '0;
         byte_idx <= '0;
      end else if (load) begin
         for (int i = 0; i < LANES; i++) hold[i] <= lane_data[i];
         byte_idx <= '0;
      end else if (advance) begin
         byte_idx <= byte_idx + 2'd1;
      end
   end

   // The clamp sits on the output mux so it adds no pipeline stage.
   always_comb begin
`ifdef OFM_READER_RELU_EN
      out_data = relu(hold[byte_idx]);
`else
      out_data = hold[byte_idx];
`endif
   end

endmodule

// File: rtl/ofm_reader.sv
// Drains DEPTH OFM words from base_addr onto a valid/ready byte stream; OFM_READER_RELU_EN clamps bytes.
// First byte appears 3 cycles after start; the FSM stalls in SEND while out_ready is low.
module ofm_reader
   import cnn_pkg::*;
#(
   parameter int DEPTH  = 25,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  byte_t             mem_data [0:LANES-1],
   output byte_t             out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              busy,
   output logic              finished
);

   localparam int WORD_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(DEPTH - 1);

   ofm_rd_state_t     state_q, state_d;
   logic [ADDR_W-1:0] base_q;
   logic [WORD_W-1:0] word_q;
   logic [1:0]        byte_idx;
   logic              last_word;
   logic              word_done;

   assign last_word = (word_q == LAST_WORD);
   assign word_done = (state_q == SEND) && out_ready && (byte_idx == 2'd3);

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         base_q <= '0;
         word_q <= '0;
      end else if (state_q == IDLE && start) begin
         base_q <= base_addr;
         word_q <= '0;
      end else if (word_done && !last_word) begin
         word_q <= word_q + WORD_W'(1);
      end
   end

   always_comb begin
      state_d   = state_q;
      mem_rd    = 1'b0;
      out_valid = 1'b0;
      finished  = 1'b0;
      case (state_q)
         IDLE: if (start) state_d = RD;
         RD: begin
            mem_rd  = 1'b1;
            state_d = LAT;
         end
         LAT:  state_d = SEND;
         SEND: begin
            out_valid = 1'b1;
            if (word_done) state_d = last_word ? FIN : RD;
         end
         FIN: begin
            finished = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Address wraps modulo 2^ADDR_W by design; no bounds check.
   assign mem_addr = base_q + ADDR_W'(word_q);
   assign busy     = (state_q != IDLE);
   assign out_last = (state_q == SEND) && (byte_idx == 2'd3) && last_word;

   ofm_serializer u_ser (
      .clk       (clk),
      .rst       (rst),
      .load      (state_q == LAT),
      .advance   ((state_q == SEND) && out_ready),
      .lane_data (mem_data),
      .byte_idx  (byte_idx),
      .out_data  (out_data)
   );

endmodule

// File: tb/tb_ofm_reader.sv
// Bench for ofm_reader: directed map table, stall/restart/reset sequences, and random maps vs a byte-list model.
module tb_ofm_reader;

   localparam int DEPTH  = 2;
   localparam int ADDR_W = 32;

   logic              clk = 1'b0;
   logic              rst, start, out_ready;
   logic [ADDR_W-1:0] base_addr;
   logic              mem_rd;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_data [0:3];
   logic [7:0]        out_data;
   logic              out_valid, out_last, busy, finished;

   ofm_reader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .mem_rd    (mem_rd),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .busy      (busy),
      .finished  (finished)
   );

   always #5 clk = ~clk;

   // Sparse OFM contents; unwritten addresses return an address-derived pattern.
   logic [31:0] mem [logic [31:0]];

   function automatic logic [31:0] rd_word(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return a ^ 32'h5A3C_96E1;
   endfunction

   function automatic logic [7:0] ref_byte(input logic [7:0] b);
`ifdef OFM_READER_RELU_EN
      return (b >= 8'd128) ? 8'd0 : b;
`else
      return b;
`endif
   endfunction

   // Synchronous-read memory; garbage outside read-response cycles.
   always @(posedge clk) begin : mem_model
      logic [31:0] w;
      w = mem_rd ? rd_word(mem_addr) : $urandom;
      for (int i = 0; i < 4; i++) mem_data[i] <= w[31-8*i -: 8];
   end

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   logic [7:0]  byte_q [$];
   bit          last_q [$];
   logic [31:0] addr_q [$];
   int fin_cnt, fin_cyc, first_vld, stall_bad, stall_cnt, busy_bad;
   bit rst_hit;

   // mode 0: ready high; 1: random ready; 2: ready low 3 cycles while third byte is shown.
   task automatic run_map(input logic [31:0] base, input int mode, input bit pulse_start, input int rst_at);
      int k, post, stall_left;
      bit prev_stall;
      logic [7:0] prev_data;
      logic prev_last;
      byte_q.delete(); last_q.delete(); addr_q.delete();
      fin_cnt = 0; fin_cyc = -1; first_vld = -1; stall_bad = 0; stall_cnt = 0; busy_bad = 0;
      rst_hit = 0; prev_stall = 0; prev_data = '0; prev_last = 0; post = 0; stall_left = 3;
      base_addr = base; start = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0; k = 0;
      for (int t = 0; t < 300; t++) begin
         case (mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            default: begin
               if (out_valid && byte_q.size() == 2 && stall_left > 0) begin
                  out_ready = 1'b0; stall_left--; stall_cnt++;
               end else out_ready = 1'b1;
            end
         endcase
         start = pulse_start && out_valid && (byte_q.size() == 1);
         if (rst_at >= 0 && out_valid && byte_q.size() == rst_at) begin
            rst = 1'b1; rst_hit = 1;
         end
         if (out_valid && first_vld < 0) first_vld = k + 1;
         if (mem_rd) addr_q.push_back(mem_addr);
         if (prev_stall && (!out_valid || out_data !== prev_data || out_last !== prev_last)) stall_bad++;
         prev_stall = out_valid && !out_ready;
         prev_data = out_data; prev_last = out_last;
         if (out_valid && out_ready && !rst_hit) begin
            byte_q.push_back(out_data); last_q.push_back(out_last);
         end
         if (fin_cnt == 0) begin
            if (!busy) busy_bad++;
         end else if (!finished && (busy || out_valid || mem_rd)) busy_bad++;
         if (finished) begin
            fin_cnt++;
            if (fin_cyc < 0) fin_cyc = k + 1;
         end
         @(posedge clk); #1;
         k++; start = 1'b0;
         if (rst_hit) begin
            rst = 1'b0;
            break;
         end
         if (fin_cnt > 0) begin
            post++;
            if (post > 4) break;
         end
      end
   endtask

   task automatic pack(output logic [63:0] b, output logic [7:0] l);
      b = '0; l = '0;
      for (int i = 0; i < byte_q.size() && i < 8; i++) begin
         b = {b[55:0], byte_q[i]};
         l = {l[6:0], last_q[i]};
      end
   endtask

   task automatic chk_idle_outputs(input string name);
      chk({name, "_ctrl"}, {59'd0, mem_rd, out_valid, out_last, busy, finished}, 64'd0);
      chk({name, "_addr"}, 64'(mem_addr), 64'd0);
      chk({name, "_data"}, 64'(out_data), 64'd0);
   endtask

   typedef struct {
      logic [31:0] base;
      logic [31:0] w0, w1;
      logic [63:0] exp_bytes;
      logic [31:0] exp_a1;
   } vec_t;

   vec_t vecs [3];

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [63:0] gb, eb;
      logic [7:0]  gl;
      logic [31:0] a0, a1;

      vecs[0] = '{32'h0000_0010, 32'h0102_0304, 32'h0506_0708, 64'h0102_0304_0506_0708, 32'h0000_0011};
`ifdef OFM_READER_RELU_EN
      vecs[1] = '{32'hFFFF_FFFF, 32'h807F_FF00, 32'h1122_3344, 64'h007F_0000_1122_3344, 32'h0000_0000};
      vecs[2] = '{32'h0000_1234, 32'hDEAD_BEEF, 32'h00FF_7F81, 64'h0000_0000_0000_7F00, 32'h0000_1235};
`else
      vecs[1] = '{32'hFFFF_FFFF, 32'h807F_FF00, 32'h1122_3344, 64'h807F_FF00_1122_3344, 32'h0000_0000};
      vecs[2] = '{32'h0000_1234, 32'hDEAD_BEEF, 32'h00FF_7F81, 64'hDEAD_BEEF_00FF_7F81, 32'h0000_1235};
`endif

      rst = 1'b1; start = 1'b0; out_ready = 1'b0; base_addr = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk_idle_outputs("reset");

      for (int i = 0; i < 3; i++) begin
         mem[vecs[i].base] = vecs[i].w0;
         mem[vecs[i].base + 32'd1] = vecs[i].w1;
         run_map(vecs[i].base, 0, 0, -1);
         pack(gb, gl);
         a0 = (addr_q.size() > 0) ? addr_q[0] : 'x;
         a1 = (addr_q.size() > 1) ? addr_q[1] : 'x;
         chk($sformatf("v%0d_nbytes", i), 64'(byte_q.size()), 64'd8);
         chk($sformatf("v%0d_bytes", i), gb, vecs[i].exp_bytes);
         chk($sformatf("v%0d_nreads", i), 64'(addr_q.size()), 64'd2);
         chk($sformatf("v%0d_addr0", i), 64'(a0), 64'(vecs[i].base));
         chk($sformatf("v%0d_addr1", i), 64'(a1), 64'(vecs[i].exp_a1));
         chk($sformatf("v%0d_last", i), 64'(gl), 64'h01);
         chk($sformatf("v%0d_fin_cnt", i), 64'(fin_cnt), 64'd1);
         chk($sformatf("v%0d_fin_cyc", i), 64'(fin_cyc), 64'd13);
         chk($sformatf("v%0d_first_vld", i), 64'(first_vld), 64'd3);
         chk($sformatf("v%0d_busy", i), 64'(busy_bad), 64'd0);
      end

      // Backpressure: three stalled cycles on byte 03.
      mem[32'h10] = 32'h0102_0304; mem[32'h11] = 32'h0506_0708;
      run_map(32'h10, 2, 0, -1);
      pack(gb, gl);
      chk("stall_bytes", gb, 64'h0102_0304_0506_0708);
      chk("stall_nbytes", 64'(byte_q.size()), 64'd8);
      chk("stall_cycles", 64'(stall_cnt), 64'd3);
      chk("stall_stable", 64'(stall_bad), 64'd0);
      chk("stall_last", 64'(gl), 64'h01);
      chk("stall_fin_cyc", 64'(fin_cyc), 64'd16);

      // Restart attempt while sending is ignored.
      run_map(32'h10, 0, 1, -1);
      pack(gb, gl);
      chk("restart_bytes", gb, 64'h0102_0304_0506_0708);
      chk("restart_nbytes", 64'(byte_q.size()), 64'd8);
      chk("restart_fin_cnt", 64'(fin_cnt), 64'd1);
      chk("restart_idle_after", 64'(busy_bad), 64'd0);

      // Reset while byte 06 is presented.
      run_map(32'h10, 0, 0, 5);
      chk_idle_outputs("midrst");
      chk("midrst_nbytes", 64'(byte_q.size()), 64'd5);
      chk("midrst_no_fin", 64'(fin_cnt), 64'd0);
      run_map(32'h10, 0, 0, -1);
      pack(gb, gl);
      chk("after_rst_bytes", gb, 64'h0102_0304_0506_0708);
      chk("after_rst_fin_cnt", 64'(fin_cnt), 64'd1);

      // start coincident with rst: reset wins.
      rst = 1'b1; start = 1'b1; base_addr = 32'h10;
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0;
      chk("rst_start_busy0", 64'(busy), 64'd0);
      @(posedge clk); #1;
      chk("rst_start_busy1", 64'(busy), 64'd0);

      // Random maps with random backpressure against the byte-list model.
      for (int it = 0; it < 12; it++) begin
         logic [31:0] base, w;
         logic [63:0] ea;
         base = (it % 4 == 0) ? 32'hFFFF_FFFF : 32'($urandom);
         for (int wi = 0; wi < DEPTH; wi++) mem[base + 32'(wi)] = 32'($urandom);
         eb = '0; ea = '0;
         for (int wi = 0; wi < DEPTH; wi++) begin
            w = mem[base + 32'(wi)];
            ea = {ea[31:0], base + 32'(wi)};
            for (int ln = 0; ln < 4; ln++) eb = {eb[55:0], ref_byte(w[31-8*ln -: 8])};
         end
         run_map(base, 1, 0, -1);
         pack(gb, gl);
         a0 = (addr_q.size() > 0) ? addr_q[0] : 'x;
         a1 = (addr_q.size() > 1) ? addr_q[1] : 'x;
         chk($sformatf("rnd%0d_bytes", it), gb, eb);
         chk($sformatf("rnd%0d_nbytes", it), 64'(byte_q.size()), 64'(4 * DEPTH));
         chk($sformatf("rnd%0d_addrs", it), {a0, a1}, ea);
         chk($sformatf("rnd%0d_last", it), 64'(gl), 64'h01);
         chk($sformatf("rnd%0d_fin_cnt", it), 64'(fin_cnt), 64'd1);
         chk($sformatf("rnd%0d_stable", it), 64'(stall_bad), 64'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
